// File: rtl/rand_spawn_ctrl.sv
// rand_spawn_ctrl: turns the free-running LFSR word into spawn requests.
// A request fires when rnd < threshold while ARMED. The request carries a
// lane index that never equals the previously accepted lane. It is held on a
// valid/ack handshake, and each accepted spawn is followed by a fixed cool-down.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | spawner disarmed, waiting for enable
// COOLDOWN | minimum gap after an accepted spawn, rnd ignored
// ARMED    | sampling rnd every cycle for a hit
// REQUEST  | spawn_valid held with a stable lane until spawn_ack
module rand_spawn_ctrl #(
  parameter int LANES   = 8,
  parameter int MIN_GAP = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               rnd,
  input  logic                     enable,
  input  logic [9:0]               threshold,
  input  logic                     spawn_ack,
  output logic                     spawn_valid,
  output logic [$clog2(LANES)-1:0] spawn_lane,
  output logic [7:0]               spawn_count,
  output logic                     busy
);

  localparam int LW = $clog2(LANES);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COOLDOWN = 2'd1;
  localparam logic [1:0] ARMED    = 2'd2;
  localparam logic [1:0] REQUEST  = 2'd3;

  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [LW-1:0] last_lane_q, last_lane_d;
  logic [7:0]    gap_q, gap_d;
  logic [7:0]    count_q, count_d;

  logic [LW-1:0] cand;
  logic          hit;

  // The lane candidate is taken from the top LW bits of the random word.
  assign cand = rnd[9 -: LW];
  assign hit  = (rnd < threshold);

  // Next-state and datapath decisions for the spawner FSM.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    lane_d      = lane_q;
    last_lane_d = last_lane_q;
    gap_d       = gap_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d = REQUEST;
          valid_d = 1'b1;
          // Never repeat the last lane; LW-bit addition wraps mod LANES.
          if (cand == last_lane_q) begin
            lane_d = cand + 1'b1;
          end else begin
            lane_d = cand;
          end
        end
      end

      REQUEST: begin
        // The request is never withdrawn; only an ack ends it.
        if (spawn_ack) begin
          valid_d     = 1'b0;
          last_lane_d = lane_q;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (enable) begin
            state_d = COOLDOWN;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      COOLDOWN: begin
        if (!enable) begin
          state_d = IDLE;
          gap_d   = 8'd0;
        end else if (gap_q == 8'd0) begin
          state_d = ARMED;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with immediate clear on reset; a pending request is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      lane_q      <= '0;
      last_lane_q <= '0;
      gap_q       <= 8'd0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      lane_q      <= lane_d;
      last_lane_q <= last_lane_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_lane  = lane_q;
  assign spawn_count = count_q;
  assign busy        = (state_q == COOLDOWN) || (state_q == REQUEST);

endmodule
